// File: rtl/aes_pkg.sv
// aes_pkg: shared AES datapath types
package aes_pkg;

   typedef enum logic {
      CTR_INC_FULL = 1'b0,
      CTR_INC_32   = 1'b1
   } ctr_mode_e;

endpackage

// File: rtl/aes_ctr_gen.sv
// aes_ctr_gen: sliced CTR-mode counter engine with step, inc32 mode, wrap flag and abort
module aes_ctr_gen
   import aes_pkg::*;
#(
   parameter int CtrWidth    = 128,
   parameter int SliceWidth  = 16,
   parameter int StepWidth   = 8,
   parameter int Inc32Enable = 1
) (
   input  logic                           clk_i,
   input  logic                           rst_i,
   input  logic                           incr_i,
   output logic                           ready_o,
   input  logic [CtrWidth-1:0]            ctr_i,
   input  logic [StepWidth-1:0]           step_i,
   input  logic                           mode_i,
   input  logic                           abort_i,
   output logic [CtrWidth-1:0]            ctr_o,
   output logic [CtrWidth/SliceWidth-1:0] ctr_we_o,
   output logic                           done_o,
   output logic                           wrap_o
);

   localparam int NumSlices = CtrWidth / SliceWidth;
   localparam int IdxW      = (NumSlices > 1) ? $clog2(NumSlices) : 1;
   localparam int Limit32   = (Inc32Enable != 0) ? 32 / SliceWidth : NumSlices;
   localparam logic [IdxW-1:0] LastFull = IdxW'(NumSlices - 1);
   localparam logic [IdxW-1:0] Last32   = IdxW'(Limit32 - 1);

   if (CtrWidth % SliceWidth != 0) begin : g_chk_slice
      $error("CtrWidth must be a multiple of SliceWidth");
   end
   if (StepWidth > SliceWidth) begin : g_chk_step
      $error("StepWidth must not exceed SliceWidth");
   end
   if (Inc32Enable != 0 && 32 % SliceWidth != 0) begin : g_chk_inc32
      $error("SliceWidth must divide 32 when Inc32Enable is set");
   end
   if (Inc32Enable != 0 && CtrWidth < 32) begin : g_chk_width
      $error("CtrWidth must be at least 32 when Inc32Enable is set");
   end

   typedef enum logic {IDLE, INCR} state_e;

   state_e                r_state, w_state_nxt;
   logic [CtrWidth-1:0]   r_ctr, w_ctr_nxt, w_ctr_upd;
   logic [SliceWidth-1:0] r_carry, w_carry_nxt;
   logic [IdxW-1:0]       r_idx, w_idx_nxt;
   ctr_mode_e             r_mode, w_mode_nxt;
   logic [SliceWidth:0]   w_sum;
   logic                  w_last;
   logic                  w_done;

   assign w_sum  = {1'b0, r_ctr[r_idx*SliceWidth +: SliceWidth]} + {1'b0, r_carry};
   assign w_last = r_idx == ((r_mode == CTR_INC_32) ? Last32 : LastFull);
   assign w_done = !w_sum[SliceWidth] || w_last;

   // working counter with the current slice replaced by the adder result
   always_comb begin
      w_ctr_upd = r_ctr;
      w_ctr_upd[r_idx*SliceWidth +: SliceWidth] = w_sum[SliceWidth-1:0];
   end

   // next-state, operand latching and output decode
   always_comb begin
      w_state_nxt = r_state;
      w_ctr_nxt   = r_ctr;
      w_carry_nxt = r_carry;
      w_idx_nxt   = r_idx;
      w_mode_nxt  = r_mode;
      ready_o     = 1'b0;
      ctr_o       = r_ctr;
      ctr_we_o    = '0;
      done_o      = 1'b0;
      wrap_o      = 1'b0;
      if (r_state == IDLE) begin
         ready_o = 1'b1;
         if (incr_i) begin
            w_state_nxt = INCR;
            w_ctr_nxt   = ctr_i;
            w_carry_nxt = SliceWidth'(step_i);
            w_idx_nxt   = '0;
            w_mode_nxt  = (Inc32Enable != 0 && mode_i) ? CTR_INC_32 : CTR_INC_FULL;
         end
      end else if (abort_i) begin
         w_state_nxt = IDLE;
      end else begin
         ctr_o           = w_ctr_upd;
         ctr_we_o[r_idx] = 1'b1;
         done_o          = w_done;
         wrap_o          = w_sum[SliceWidth] && w_last;
         w_ctr_nxt       = w_ctr_upd;
         w_carry_nxt     = SliceWidth'(w_sum[SliceWidth]);
         w_idx_nxt       = r_idx + IdxW'(1);
         if (w_done) w_state_nxt = IDLE;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= IDLE;
         r_ctr   <= '0;
         r_carry <= '0;
         r_idx   <= '0;
         r_mode  <= CTR_INC_FULL;
      end else begin
         r_state <= w_state_nxt;
         r_ctr   <= w_ctr_nxt;
         r_carry <= w_carry_nxt;
         r_idx   <= w_idx_nxt;
         r_mode  <= w_mode_nxt;
      end
   end

endmodule
